// File: rtl/tc_mult_pkg.sv
// tc_mult_pkg: default widths and request/result records shared by the multiplier arbiter and its FIFO.
package tc_mult_pkg;
    localparam int TC_NREQ  = 4;
    localparam int TC_A_W   = 17;
    localparam int TC_B_W   = 16;
    localparam int TC_P_W   = 31;
    localparam int TC_TAG_W = 8;
    localparam int TC_ID_W  = $clog2(TC_NREQ);

    typedef struct packed {
        logic [TC_A_W-1:0]   a;
        logic [TC_B_W-1:0]   b;
        logic [TC_TAG_W-1:0] tag;
    } mult_req_t;

    typedef struct packed {
        logic [TC_P_W-1:0]   p;
        logic [TC_ID_W-1:0]  id;
        logic [TC_TAG_W-1:0] tag;
    } mult_res_t;

    // The low product bits only depend on the low operand bits, so truncating the signed product is exact.
    function automatic logic [TC_P_W-1:0] mult_trunc(input logic [TC_A_W-1:0] a, input logic [TC_B_W-1:0] b);
        return TC_P_W'($signed(a) * $signed({1'b0, b}));
    endfunction
endpackage

// File: rtl/tc_mult_res_fifo.sv
// tc_mult_res_fifo: show-ahead FIFO of multiplier results with occupancy count.
module tc_mult_res_fifo
    import tc_mult_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_wr,
    input  mult_res_t                  i_wr_data,
    input  logic                       i_rd,
    output mult_res_t                  o_rd_data,
    output logic [$clog2(DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    mult_res_t r_mem [DEPTH];
    logic [PW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic w_rd;

    assign w_rd      = i_rd && r_cnt != '0;
    assign o_rd_data = r_mem[r_rp];
    assign o_count   = r_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wp  <= '0;
            r_rp  <= '0;
            r_cnt <= '0;
        end else begin
            if (i_wr) begin
                r_mem[r_wp] <= i_wr_data;
                r_wp        <= (r_wp == PW'(DEPTH-1)) ? '0 : r_wp + 1'b1;
            end
            if (w_rd) r_rp <= (r_rp == PW'(DEPTH-1)) ? '0 : r_rp + 1'b1;
            if (i_wr != w_rd) r_cnt <= i_wr ? r_cnt + 1'b1 : r_cnt - 1'b1;
        end
    end

    assert property (@(posedge i_clk) disable iff (i_rst) !(i_wr && r_cnt == CW'(DEPTH)));
endmodule

// File: rtl/tc_mult_share_arbiter.sv
// tc_mult_share_arbiter: round-robin shared signed x unsigned multiplier with credit-throttled result FIFO.
// Define MULT_OUT_REG_EN to add an output register after the multiplier (latency LAT+1).
module tc_mult_share_arbiter
    import tc_mult_pkg::*;
#(
    parameter int NREQ  = TC_NREQ,
    parameter int A_W   = TC_A_W,
    parameter int B_W   = TC_B_W,
    parameter int P_W   = TC_P_W,
    parameter int LAT   = 2,
    parameter int TAG_W = TC_TAG_W,
    parameter int DEPTH = 4
) (
    input  logic                    ap_clk,
    input  logic                    ap_rst,
    input  logic [NREQ-1:0]         req_valid,
    output logic [NREQ-1:0]         req_ready,
    input  logic [NREQ*A_W-1:0]     req_a,
    input  logic [NREQ*B_W-1:0]     req_b,
    input  logic [NREQ*TAG_W-1:0]   req_tag,
    output logic                    res_valid,
    input  logic                    res_ready,
    output logic [P_W-1:0]          res_p,
    output logic [$clog2(NREQ)-1:0] res_id,
    output logic [TAG_W-1:0]        res_tag
);
    localparam int ID_W = $clog2(NREQ);
    localparam int CR_W = $clog2(DEPTH+1);
`ifdef MULT_OUT_REG_EN
    localparam int NSTG = LAT;
`else
    localparam int NSTG = LAT - 1;
`endif

    logic [ID_W-1:0] r_rr, w_gnt;
    logic [CR_W-1:0] r_credits, w_cnt;
    logic w_any, w_credit_ok, w_issue, w_pop, w_wr;
    mult_req_t w_req;
    mult_res_t w_new, w_wr_data, w_head;

    assign w_credit_ok = r_credits < CR_W'(DEPTH);

    // Descending scan so the requester nearest to r_rr is the last (winning) assignment.
    always_comb begin
        w_any = 1'b0;
        w_gnt = '0;
        for (int k = NREQ - 1; k >= 0; k--)
            if (req_valid[(int'(r_rr) + k) % NREQ]) begin
                w_any = 1'b1;
                w_gnt = ID_W'((int'(r_rr) + k) % NREQ);
            end
    end

    assign w_issue   = w_any & w_credit_ok & ~ap_rst;
    assign req_ready = w_issue ? NREQ'(1) << w_gnt : '0;
    assign w_pop     = res_valid & res_ready;
    assign w_req     = {req_a[w_gnt*A_W +: A_W], req_b[w_gnt*B_W +: B_W], req_tag[w_gnt*TAG_W +: TAG_W]};
    assign w_new     = {mult_trunc(w_req.a, w_req.b), w_gnt, w_req.tag};

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            r_rr      <= '0;
            r_credits <= '0;
        end else begin
            if (w_issue) r_rr <= (w_gnt == ID_W'(NREQ-1)) ? '0 : w_gnt + 1'b1;
            if (w_issue != w_pop) r_credits <= w_issue ? r_credits + 1'b1 : r_credits - 1'b1;
        end
    end

    generate
        if (NSTG == 0) begin : g_comb
            assign w_wr      = w_issue;
            assign w_wr_data = w_new;
        end else begin : g_pipe
            mult_res_t r_pipe [NSTG];
            logic [NSTG-1:0] r_pv;
            always_ff @(posedge ap_clk or posedge ap_rst) begin
                if (ap_rst) begin
                    r_pv <= '0;
                    for (int s = 0; s < NSTG; s++) r_pipe[s] <= '0;
                end else begin
                    r_pv[0]   <= w_issue;
                    r_pipe[0] <= w_new;
                    for (int s = 1; s < NSTG; s++) begin
                        r_pv[s]   <= r_pv[s-1];
                        r_pipe[s] <= r_pipe[s-1];
                    end
                end
            end
            assign w_wr      = r_pv[NSTG-1];
            assign w_wr_data = r_pipe[NSTG-1];
        end
    endgenerate

    tc_mult_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk     (ap_clk),
        .i_rst     (ap_rst),
        .i_wr      (w_wr),
        .i_wr_data (w_wr_data),
        .i_rd      (w_pop),
        .o_rd_data (w_head),
        .o_count   (w_cnt)
    );

    assign res_valid = w_cnt != '0;
    assign res_p     = w_head.p;
    assign res_id    = w_head.id;
    assign res_tag   = w_head.tag;

    assert property (@(posedge ap_clk) disable iff (ap_rst) r_credits <= CR_W'(DEPTH));
endmodule
